// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that lets two requesters share one
// combinational ALU. One operation in flight at a time: IDLE -> EXEC -> RESP.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [2:0]       req_ctrl_0,
  input  logic [2:0]       req_ctrl_1,
  input  logic [2:0]       req_funct3_0,
  input  logic [2:0]       req_funct3_1,
  input  logic             req_funct7b5_0,
  input  logic             req_funct7b5_1,
  output logic             rsp_valid_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_0,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_data_0,
  output logic [WIDTH-1:0] rsp_data_1,
  output logic             rsp_zero_0,
  output logic             rsp_zero_1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  output logic [2:0]       alu_funct3,
  output logic             alu_funct7b5,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy,
  output logic             grant_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             gid_q, gid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       ctrl_q, ctrl_d, f3_q, f3_d;
  logic             f7_q, f7_d, zero_q, zero_d;
  logic             any_req, grant;

  // Round-robin pick: on a tie the requester not served last wins;
  // otherwise whichever one is valid.
  always_comb begin
    any_req = req_valid_0 | req_valid_1;
    if (req_valid_0 && req_valid_1) grant = ~last_q;
    else                            grant = req_valid_1;
    req_ready_0 = (state_q == IDLE) && req_valid_0 && !grant;
    req_ready_1 = (state_q == IDLE) && req_valid_1 && grant;
  end

  // Next-state: latch the winner's fields on accept, capture the ALU in EXEC,
  // wait for the owner's rsp_ready in RESP.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = EXEC;
          last_d  = grant;
          gid_d   = grant;
          a_d     = grant ? req_a_1        : req_a_0;
          b_d     = grant ? req_b_1        : req_b_0;
          ctrl_d  = grant ? req_ctrl_1     : req_ctrl_0;
          f3_d    = grant ? req_funct3_1   : req_funct3_0;
          f7_d    = grant ? req_funct7b5_1 : req_funct7b5_0;
        end
      end
      EXEC: begin
        res_d   = alu_out;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (gid_q ? rsp_ready_1 : rsp_ready_0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and points the
  // last grant at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      f3_q    <= '0;
      f7_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  // Output decode: ALU is driven only during EXEC, responses only in RESP
  // and only toward the owner; everything else reads as zero.
  always_comb begin
    busy         = (state_q != IDLE);
    grant_id     = gid_q;
    alu_a        = (state_q == EXEC) ? a_q    : '0;
    alu_b        = (state_q == EXEC) ? b_q    : '0;
    alu_ctrl     = (state_q == EXEC) ? ctrl_q : '0;
    alu_funct3   = (state_q == EXEC) ? f3_q   : '0;
    alu_funct7b5 = (state_q == EXEC) && f7_q;
    rsp_valid_0  = (state_q == RESP) && !gid_q;
    rsp_valid_1  = (state_q == RESP) && gid_q;
    rsp_data_0   = rsp_valid_0 ? res_q : '0;
    rsp_data_1   = rsp_valid_1 ? res_q : '0;
    rsp_zero_0   = rsp_valid_0 && zero_q;
    rsp_zero_1   = rsp_valid_1 && zero_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural shared ALU, table of single-op vectors,
// plus hand sequences for round-robin, back-pressure and mid-op reset.
module tb_alu_arbiter;

  localparam int W = 32;
  localparam logic [2:0] C_ADD = 3'b000, C_SUB = 3'b001, C_AND = 3'b010,
                         C_OR  = 3'b011, C_XOR = 3'b100, C_SLT = 3'b101,
                         C_SLL = 3'b110, C_SR  = 3'b111;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [W-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic [2:0]   req_ctrl_0, req_ctrl_1, req_funct3_0, req_funct3_1;
  logic         req_funct7b5_0, req_funct7b5_1;
  logic         rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
  logic [W-1:0] rsp_data_0, rsp_data_1;
  logic         rsp_zero_0, rsp_zero_1;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_ctrl, alu_funct3;
  logic         alu_funct7b5, alu_zero;
  logic         busy, grant_id;

  typedef struct {
    bit          id;
    logic [2:0]  ctrl;
    logic [2:0]  f3;
    bit          f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    bit          z;
  } vec_t;

  typedef struct {
    bit          id;
    logic [31:0] data;
    bit          zero;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[11];
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_a_0(req_a_0), .req_b_0(req_b_0), .req_a_1(req_a_1), .req_b_1(req_b_1),
    .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
    .req_funct3_0(req_funct3_0), .req_funct3_1(req_funct3_1),
    .req_funct7b5_0(req_funct7b5_0), .req_funct7b5_1(req_funct7b5_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
    .rsp_zero_0(rsp_zero_0), .rsp_zero_1(rsp_zero_1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_funct3(alu_funct3), .alu_funct7b5(alu_funct7b5),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .busy(busy), .grant_id(grant_id)
  );

  // Shared ALU model
  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      C_ADD: alu_out = alu_a + alu_b;
      C_SUB: alu_out = alu_a - alu_b;
      C_AND: alu_out = alu_a & alu_b;
      C_OR:  alu_out = alu_a | alu_b;
      C_XOR: begin
        if (alu_funct3 == 3'b011) alu_out = {31'b0, alu_a < alu_b};
        else                      alu_out = alu_a ^ alu_b;
      end
      C_SLT: alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      C_SLL: alu_out = alu_a << alu_b[4:0];
      default: begin
        if (alu_funct7b5) alu_out = $signed(alu_a) >>> alu_b[4:0];
        else              alu_out = alu_a >> alu_b[4:0];
      end
    endcase
  end
  assign alu_zero = (alu_out == '0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input bit id);
    return id ? req_ready_1 : req_ready_0;
  endfunction
  function automatic logic rvld(input bit id);
    return id ? rsp_valid_1 : rsp_valid_0;
  endfunction
  function automatic logic [W-1:0] rdat(input bit id);
    return id ? rsp_data_1 : rsp_data_0;
  endfunction
  function automatic logic rzero(input bit id);
    return id ? rsp_zero_1 : rsp_zero_0;
  endfunction

  task automatic set_req(input bit id, input bit v, input logic [2:0] c, input logic [2:0] f3,
                         input bit f7, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin
      req_valid_1 = v; req_ctrl_1 = c; req_funct3_1 = f3; req_funct7b5_1 = f7;
      req_a_1 = a; req_b_1 = b;
    end else begin
      req_valid_0 = v; req_ctrl_0 = c; req_funct3_0 = f3; req_funct7b5_0 = f7;
      req_a_0 = a; req_b_0 = b;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input bit id, output int lat);
    lat = 0;
    while (!rvld(id) && lat < 10) begin
      cyc();
      lat++;
    end
  endtask

  // One complete transaction; operands are scrambled right after acceptance.
  task automatic issue(input vec_t v);
    int  lat;
    sb_t e;
    set_req(v.id, 1'b1, v.ctrl, v.f3, v.f7, v.a, v.b);
    #1;
    lat = 0;
    while (!rdy(v.id) && lat < 20) begin
      cyc();
      lat++;
    end
    check("accept_ready", rdy(v.id), 1);
    check("accept_other_ready", rdy(!v.id), 0);
    if (!rdy(v.id)) begin
      set_req(v.id, 1'b0, 3'b0, 3'b0, 1'b0, '0, '0);
      return;
    end
    sb_q.push_back('{v.id, v.d, v.z});
    cyc();
    set_req(v.id, 1'b0, ~v.ctrl, ~v.f3, ~v.f7, ~v.a, ~v.b);
    #1;
    check("exec_alu_a", alu_a, v.a);
    check("exec_busy", busy, 1);
    check("exec_grant_id", grant_id, v.id);
    wait_rsp(v.id, lat);
    check("rsp_latency", lat, 1);
    check("rsp_other_valid", rvld(!v.id), 0);
    check("rsp_other_data", rdat(!v.id), 0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rsp_data", rdat(v.id), e.data);
      check("rsp_zero", rzero(v.id), e.zero);
    end
    if (v.id) rsp_ready_1 = 1'b1; else rsp_ready_0 = 1'b1;
    cyc();
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int  lat, grants, cycles;
    bit  order[3];
    bit  g;
    sb_t e;

    vecs[0]  = '{1'b0, C_ADD, 3'b000, 1'b0, 32'd5,        32'd7,        32'd12,       1'b0};
    vecs[1]  = '{1'b1, C_SUB, 3'b000, 1'b1, 32'd9,        32'd9,        32'd0,        1'b1};
    vecs[2]  = '{1'b1, C_SR,  3'b101, 1'b1, 32'h80000000, 32'd4,        32'hF8000000, 1'b0};
    vecs[3]  = '{1'b0, C_AND, 3'b111, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
    vecs[4]  = '{1'b1, C_OR,  3'b110, 1'b0, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0};
    vecs[5]  = '{1'b0, C_XOR, 3'b100, 1'b0, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0};
    vecs[6]  = '{1'b1, C_XOR, 3'b011, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0};
    vecs[7]  = '{1'b0, C_SLT, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    vecs[8]  = '{1'b1, C_SLL, 3'b001, 1'b0, 32'd1,        32'd31,       32'h80000000, 1'b0};
    vecs[9]  = '{1'b0, C_SR,  3'b101, 1'b0, 32'h80000000, 32'd4,        32'h08000000, 1'b0};
    vecs[10] = '{1'b0, C_ADD, 3'b000, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};

    reset = 1'b0;
    set_req(1'b0, 1'b0, 3'b0, 3'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 3'b0, 3'b0, 1'b0, '0, '0);
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    cyc();
    cyc();
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_rsp_valid", {rsp_valid_1, rsp_valid_0}, 0);
    check("rst_rsp_data", {rsp_data_1, rsp_data_0}, 0);
    check("rst_alu", {alu_a, alu_b, alu_ctrl, alu_funct3, alu_funct7b5}, 0);
    reset = 1'b1;
    #1;
    check("rst_req_ready", {req_ready_1, req_ready_0}, 0);

    // Table-driven single operations
    for (int i = 0; i < 11; i++) issue(vecs[i]);

    // Both requesters held valid right after reset: strict alternation 0,1,0
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    sb_q.delete();
    set_req(1'b0, 1'b1, C_ADD, 3'b0, 1'b0, 32'd1, 32'd2);
    set_req(1'b1, 1'b1, C_ADD, 3'b0, 1'b0, 32'd10, 32'd20);
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    grants = 0;
    cycles = 0;
    while ((grants < 3 || sb_q.size() > 0) && cycles < 40) begin
      #1;
      check("rr_exclusive", req_ready_0 & req_ready_1, 0);
      if (req_ready_0 | req_ready_1) begin
        g = req_ready_1;
        order[grants] = g;
        sb_q.push_back('{g, g ? 32'd30 : 32'd3, 1'b0});
        grants++;
      end
      if ((rsp_valid_0 | rsp_valid_1) && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rr_rsp_id", rsp_valid_1, e.id);
        check("rr_rsp_data", rdat(rsp_valid_1), e.data);
      end
      cyc();
      cycles++;
      if (grants == 3) begin
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
      end
    end
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    check("rr_grants", grants, 3);
    check("rr_order0", order[0], 0);
    check("rr_order1", order[1], 1);
    check("rr_order2", order[2], 0);

    // Back-pressure in RESP while requester 1 waits
    sb_q.delete();
    set_req(1'b0, 1'b1, C_ADD, 3'b0, 1'b0, 32'd3, 32'd4);
    #1;
    lat = 0;
    while (!req_ready_0 && lat < 20) begin cyc(); lat++; end
    check("bp_accept0", req_ready_0, 1);
    sb_q.push_back('{1'b0, 32'd7, 1'b0});
    cyc();
    set_req(1'b0, 1'b0, 3'b0, 3'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b1, C_OR, 3'b0, 1'b0, 32'h30, 32'h0C);
    wait_rsp(1'b0, lat);
    check("bp_latency", lat, 1);
    for (int k = 0; k < 4; k++) begin
      check("bp_rsp_valid0", rsp_valid_0, 1);
      check("bp_rsp_data0", rsp_data_0, 7);
      check("bp_busy", busy, 1);
      check("bp_req_ready1", req_ready_1, 0);
      cyc();
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("bp_data", rsp_data_0, e.data);
    end
    rsp_ready_0 = 1'b1;
    #1;
    check("bp_release_ready1", req_ready_1, 0);
    cyc();
    rsp_ready_0 = 1'b0;
    #1;
    check("bp_idle_grant1", req_ready_1, 1);
    sb_q.push_back('{1'b1, 32'h3C, 1'b0});
    cyc();
    set_req(1'b1, 1'b0, 3'b0, 3'b0, 1'b0, '0, '0);
    wait_rsp(1'b1, lat);
    check("bp_latency1", lat, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("bp_data1", rsp_data_1, e.data);
    end
    rsp_ready_1 = 1'b1;
    cyc();
    rsp_ready_1 = 1'b0;

    // Reset while requester 1's operation is in EXEC
    set_req(1'b1, 1'b1, C_SUB, 3'b0, 1'b0, 32'd50, 32'd8);
    #1;
    lat = 0;
    while (!req_ready_1 && lat < 20) begin cyc(); lat++; end
    check("ar_accept1", req_ready_1, 1);
    cyc();
    set_req(1'b1, 1'b0, 3'b0, 3'b0, 1'b0, '0, '0);
    check("ar_exec_busy", busy, 1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    check("ar_busy", busy, 0);
    check("ar_rsp_valid", {rsp_valid_1, rsp_valid_0}, 0);
    check("ar_rsp_data", {rsp_data_1, rsp_data_0}, 0);
    check("ar_alu", {alu_a, alu_b, alu_ctrl, alu_funct3, alu_funct7b5}, 0);
    check("ar_grant_id", grant_id, 0);
    for (int k = 0; k < 3; k++) begin
      check("ar_no_rsp", {rsp_valid_1, rsp_valid_0}, 0);
      cyc();
    end
    issue('{1'b0, C_OR, 3'b110, 1'b0, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
